fifo_wr_driver: RTL and testbench

FIFO_WR_DRIVER -- requirements
Module: fifo_wr_driver

---
 rtl/fifo_wr_driver.sv | 180 ++++++++++++++++++
 tb/tb_fifo_wr_driver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_driver.sv
// fifo_wr_driver: sequences a FIFO reset, then drives programmed write bursts with optional gaps (LFSR data option: WR_DRV_LFSR_EN).
// Latency: data_in is registered and wr_en is combinational from state and full; the first write comes one cycle after start.
// Backpressure: full=1 during BURST freezes data, counters and state; the burst resumes in the cycle full falls.
module fifo_wr_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clk_wr,
  input  logic                  rst,
  input  logic                  soft_rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] data_seed,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic [CNT_WIDTH-1:0]  gap_len,
  input  logic [CNT_WIDTH-1:0]  num_bursts,
  input  logic                  full,
  output logic                  fifo_rst_n,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_count
);

  localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_RST_SEQ, S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [RCW-1:0]        rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0]  blen_q, blen_d;
  logic [CNT_WIDTH-1:0]  glen_q, glen_d;
  logic [CNT_WIDTH-1:0]  bleft_q, bleft_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  gcnt_q, gcnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           wcnt_q, wcnt_d;

`ifdef WR_DRV_LFSR_EN
  logic        mode_q, mode_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] lfsr_seed;
  logic [31:0] lfsr_next;

  // Seed the LFSR from the zero-extended seed (all-zero would lock up, so use 1) and precompute one right-shift Galois step
  always_comb begin
    lfsr_seed = (data_seed == '0) ? 32'd1 : 32'(data_seed);
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign fifo_rst_n = (state_q != S_RST_SEQ);
  assign wr_en      = (state_q == S_BURST) && !full;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign data_in    = data_q;
  assign wr_count   = wcnt_q;

  // Next-state logic: soft reset overrides everything, otherwise walk the program
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    blen_d  = blen_q;
    glen_d  = glen_q;
    bleft_d = bleft_q;
    beat_d  = beat_q;
    gcnt_d  = gcnt_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
`ifdef WR_DRV_LFSR_EN
    mode_d  = mode_q;
    lfsr_d  = lfsr_q;
`endif
    if (soft_rst) begin
      state_d = S_RST_SEQ;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        S_RST_SEQ: begin
          if (rcnt_q == RST_LAST) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        S_IDLE: begin
          if (start && (burst_len != '0) && (num_bursts != '0)) begin
            state_d = S_BURST;
            blen_d  = burst_len;
            glen_d  = gap_len;
            bleft_d = num_bursts;
            beat_d  = '0;
            wcnt_d  = '0;
            data_d  = data_seed;
`ifdef WR_DRV_LFSR_EN
            mode_d  = mode;
            lfsr_d  = lfsr_seed;
            if (mode) data_d = lfsr_seed[DATA_WIDTH-1:0];
`endif
          end
        end
        S_BURST: begin
          if (!full) begin
            if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
            data_d = data_q + DATA_WIDTH'(1);
`ifdef WR_DRV_LFSR_EN
            if (mode_q) begin
              lfsr_d = lfsr_next;
              data_d = lfsr_next[DATA_WIDTH-1:0];
            end
`endif
            if (beat_q == blen_q - CNT_WIDTH'(1)) begin
              beat_d = '0;
              if (bleft_q == CNT_WIDTH'(1)) begin
                state_d = S_DONE;
              end else begin
                bleft_d = bleft_q - CNT_WIDTH'(1);
                gcnt_d  = '0;
                if (glen_q != '0) state_d = S_GAP;
              end
            end else begin
              beat_d = beat_q + CNT_WIDTH'(1);
            end
          end
        end
        S_GAP: begin
          if (gcnt_q == glen_q - CNT_WIDTH'(1)) begin
            state_d = S_BURST;
            gcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q + CNT_WIDTH'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_RST_SEQ;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset into the FIFO reset sequence
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      state_q <= S_RST_SEQ;
      rcnt_q  <= '0;
      blen_q  <= '0;
      glen_q  <= '0;
      bleft_q <= '0;
      beat_q  <= '0;
      gcnt_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
`ifdef WR_DRV_LFSR_EN
      mode_q  <= 1'b0;
      lfsr_q  <= 32'd1;
`endif
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      blen_q  <= blen_d;
      glen_q  <= glen_d;
      bleft_q <= bleft_d;
      beat_q  <= beat_d;
      gcnt_q  <= gcnt_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
`ifdef WR_DRV_LFSR_EN
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_driver.sv
// tb_fifo_wr_driver: randomized and directed burst programs against a queue-based reference of the write stream.
// Expected words are queued at start; a negedge monitor pops and compares on every wr_en.
// full is driven by the bench to exercise stalls.
module tb_fifo_wr_driver;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int RC = 4;
`ifdef WR_DRV_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic          clk_wr = 1'b0;
  logic          rst = 1'b1;
  logic          soft_rst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          full = 1'b0;
  logic [DW-1:0] data_seed = '0;
  logic [CW-1:0] burst_len = '0;
  logic [CW-1:0] gap_len = '0;
  logic [CW-1:0] num_bursts = '0;
  logic          fifo_rst_n;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          busy;
  logic          done;
  logic [15:0]   wr_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  bit done_expected = 1'b0;
  logic [DW-1:0] exp_q[$];
  int wr_cyc[$];

  fifo_wr_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .RST_CYCLES(RC)) dut (
    .clk_wr(clk_wr), .rst(rst), .soft_rst(soft_rst), .start(start), .mode(mode),
    .data_seed(data_seed), .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
    .full(full), .fifo_rst_n(fifo_rst_n), .wr_en(wr_en), .data_in(data_in), .busy(busy),
    .done(done), .wr_count(wr_count)
  );

  always #5 clk_wr = ~clk_wr;
  always @(posedge clk_wr) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected stream; done only when a program is expected to end
  always @(negedge clk_wr) begin
    if (!rst) begin
      if (wr_en) begin
        chk("wr_en_while_full", 32'(full), 32'd0);
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("data_in", 32'(data_in), 32'(exp_q.pop_front()));
        wr_cyc.push_back(cyc);
      end
      if (done) begin
        chk("done_expected", 32'(done_expected), 32'd1);
        chk("done_stream_empty", 32'(exp_q.size()), 32'd0);
        done_expected = 1'b0;
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  // Reference: the full write stream of a program is seed, seed+1, ... or successive LFSR states
  task automatic load_prog(input int bl, input int nb, input logic [DW-1:0] seed, input bit m);
    logic [31:0] l;
    exp_q.delete();
    wr_cyc.delete();
    l = (seed == '0) ? 32'd1 : 32'(seed);
    for (int i = 0; i < bl * nb; i++) begin
      if (LFSR_ON && m) begin
        exp_q.push_back(l[DW-1:0]);
        l = lstep(l);
      end else begin
        exp_q.push_back(DW'(32'(seed) + 32'(i)));
      end
    end
  endtask

  task automatic run_start(input int bl, input int gl, input int nb, input logic [DW-1:0] seed, input bit m);
    load_prog(bl, nb, seed, m);
    done_expected = 1'b1;
    @(posedge clk_wr); #1;
    burst_len = CW'(bl); gap_len = CW'(gl); num_bursts = CW'(nb);
    data_seed = seed; mode = m; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk_wr); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int full_pct);
    int c0;
    bit ok;
    c0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_wr);
      if (done_cnt != c0) begin
        ok = 1'b1;
        break;
      end
      #1;
      full = ($urandom_range(99) < full_pct);
    end
    #1;
    full = 1'b0;
    chk("done_within_bound", 32'(ok), 32'd1);
  endtask

  task automatic chk_timing(input int bl, input int gl, input int nb);
    chk("write_total", 32'(wr_cyc.size()), 32'(bl * nb));
    if (wr_cyc.size() == bl * nb) begin
      chk("first_write_latency", 32'(wr_cyc[0] - start_cyc), 32'd1);
      for (int b = 0; b < nb; b++)
        for (int k = 0; k < bl; k++)
          chk("write_cycle", 32'(wr_cyc[b*bl+k] - wr_cyc[0]), 32'(b * (bl + gl) + k));
      chk("done_after_last", 32'(done_cyc - wr_cyc[bl*nb-1]), 32'd1);
    end
    @(negedge clk_wr);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic count_rst_seq(input string name);
    int n;
    bit wr_seen;
    n = 0;
    wr_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_wr); #1;
      if (wr_en) wr_seen = 1'b1;
      if (fifo_rst_n) begin
        n = i;
        break;
      end
    end
    chk({name, "_rst_edges"}, 32'(n), 32'(RC));
    chk({name, "_busy_fell"}, 32'(busy), 32'd0);
    chk({name, "_wr_en_quiet"}, 32'(wr_seen), 32'd0);
  endtask

  initial begin
    int bl, gl, nb, c0;
    logic [DW-1:0] frz;
    bit ok;

    // Reset state while rst is held
    repeat (3) @(negedge clk_wr);
    chk("rst_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    #2 rst = 1'b0;
    count_rst_seq("por");

    // Basic program with gaps
    run_start(3, 2, 2, 8'h10, 1'b0);
    wait_done(100, 0);
    chk("basic_wr_count", 32'(wr_count), 32'd6);
    chk_timing(3, 2, 2);

    // Back-to-back bursts with data wrap
    run_start(2, 0, 3, 8'hFE, 1'b0);
    wait_done(100, 0);
    chk("b2b_wr_count", 32'(wr_count), 32'd6);
    chk_timing(2, 0, 3);

    // start ignored with zero num_bursts or zero burst_len
    for (int t = 0; t < 2; t++) begin
      @(posedge clk_wr); #1;
      burst_len = (t == 0) ? CW'(3) : CW'(0);
      num_bursts = (t == 0) ? CW'(0) : CW'(2);
      start = 1'b1;
      @(posedge clk_wr); #1;
      start = 1'b0;
      repeat (3) begin
        @(negedge clk_wr);
        chk("ignored_start_busy", 32'(busy), 32'd0);
      end
    end

    // full held for 5 cycles mid-burst, plus a start issued while busy
    run_start(6, 1, 2, 8'h80, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_wr);
      if (wr_cyc.size() >= 3) begin ok = 1'b1; break; end
    end
    chk("stall_reached", 32'(ok), 32'd1);
    #1 full = 1'b1;
    frz = data_in;
    repeat (5) begin
      @(negedge clk_wr);
      chk("stall_wr_en", 32'(wr_en), 32'd0);
      chk("stall_data_frozen", 32'(data_in), 32'(frz));
    end
    @(posedge clk_wr); #1;
    full = 1'b0;
    data_seed = 8'h00; num_bursts = 8'd1; start = 1'b1;
    @(posedge clk_wr); #1;
    start = 1'b0;
    wait_done(100, 0);
    chk("stall_wr_count", 32'(wr_count), 32'd12);

    // Randomized programs with random backpressure
    for (int p = 0; p < 8; p++) begin
      bl = $urandom_range(5, 1);
      gl = $urandom_range(3, 0);
      nb = $urandom_range(4, 1);
      run_start(bl, gl, nb, DW'($urandom), 1'($urandom));
      wait_done(400, 30);
      chk("rand_wr_count", 32'(wr_count), 32'(bl * nb));
    end

`ifdef WR_DRV_LFSR_EN
    // LFSR pattern with a zero seed
    run_start(5, 1, 2, 8'h00, 1'b1);
    wait_done(100, 0);
    chk("lfsr_wr_count", 32'(wr_count), 32'd10);
`endif

    // soft_rst in the second burst aborts the program without done
    run_start(4, 1, 3, 8'h40, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_wr);
      if (wr_cyc.size() >= 6) begin ok = 1'b1; break; end
    end
    chk("soft_rst_reached", 32'(ok), 32'd1);
    c0 = done_cnt;
    #1 soft_rst = 1'b1;
    @(posedge clk_wr); #1;
    soft_rst = 1'b0;
    exp_q.delete();
    done_expected = 1'b0;
    chk("soft_rst_wr_en", 32'(wr_en), 32'd0);
    chk("soft_rst_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
    count_rst_seq("soft");
    repeat (3) @(posedge clk_wr);
    chk("soft_rst_no_done", 32'(done_cnt), 32'(c0));

    // Asynchronous rst in the middle of a burst
    run_start(5, 0, 2, 8'h33, 1'b0);
    repeat (3) @(posedge clk_wr);
    #3 rst = 1'b1;
    exp_q.delete();
    done_expected = 1'b0;
    #1;
    chk("arst_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_data_in", 32'(data_in), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_wr_count", 32'(wr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
